sdram_refresh_sequencer: RTL and testbench
==========================================

SDRAM_REFRESH_SEQUENCER -- requirements
Module: sdram_refresh_sequencer

Interface
REQ-001 Parameter T_RP, default 3: cycles from PRECHARGE ALL to AUTO REFRESH; legal range 2..2^BW_TIMER-1.
REQ-002 Parameter T_RFC, default 8: cycles from AUTO REFRESH to next command; legal range 2..2^BW_TIMER-1.
REQ-003 Parameter BW_TIMER, default 4: wait-timer width in bits.
REQ-004 clock_i  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_i  input  1  reset, synchronous, active-high.
REQ-006 status_i  input  1  SDRAM initialized; sequences start only while high.
REQ-007 refresh_i  input  1  refresh owed, level, from refresh controller.
REQ-008 gnt_i  input  1  arbiter grants command bus; held high until req_o falls.
REQ-009 req_o  output  1  bus request to arbiter.
REQ-010 busy_o  output  1  sequencer drives command bus this cycle.
REQ-011 cmd_o  output  4  {CS_n,RAS_n,CAS_n,WE_n}; NOP=0111, PRECHARGE=0010, AUTO REFRESH=0001.
REQ-012 a10_o  output  1  address bit 10; 1 only with PRECHARGE (all banks).
REQ-013 execute_o  output  1  one-cycle pulse, same cycle AUTO REFRESH is on cmd_o; feeds refresh controller execute input.

Function
REQ-014 States: IDLE, REQ, PRE, WAIT_RP, REF, WAIT_RFC; all outputs registered, state-decoded.
REQ-015 IDLE: req_o=0, busy_o=0, cmd_o=NOP, a10_o=0, execute_o=0; refresh_i=1 and status_i=1 -> REQ next cycle.
REQ-016 REQ: req_o=1, cmd_o=NOP, busy_o=0; gnt_i=1 sampled -> PRE next cycle; otherwise remain, no timeout.
REQ-017 PRE: single cycle, cmd_o=PRECHARGE, a10_o=1, busy_o=1, req_o=1; timer loaded T_RP-1; -> WAIT_RP.
REQ-018 WAIT_RP: cmd_o=NOP, busy_o=1; timer decrements; at 1 -> REF, so AUTO REFRESH lands exactly T_RP cycles after PRECHARGE.
REQ-019 REF: single cycle, cmd_o=AUTO REFRESH, execute_o=1, busy_o=1; timer loaded T_RFC-1; -> WAIT_RFC.
REQ-020 WAIT_RFC: cmd_o=NOP, busy_o=1; timer decrements; at 1: refresh_i=1 and status_i=1 -> REF (chained, no PRECHARGE, req_o held), else -> IDLE with req_o=0.
REQ-021 Chained AUTO REFRESH commands separated by exactly T_RFC cycles; execute_o pulses once per AUTO REFRESH, never two consecutive cycles.
REQ-022 refresh_i sampled only in IDLE and last WAIT_RFC cycle; its one-cycle lag after execute_o is tolerated by T_RFC>=2.
REQ-023 Once PRE entered, sequence always completes through WAIT_RFC; gnt_i drop, refresh_i drop or status_i drop mid-sequence do not abort; status_i=0 only blocks new/chained sequences.
REQ-024 refresh_i falling while in REQ: remain in REQ until granted (refresh controller only decrements on execute, so level cannot legally fall).
REQ-025 Timer is BW_TIMER bits, unsigned, never wraps below 1 in any legal configuration.

Reset
REQ-026 reset_i=1 at clock edge -> next cycle state IDLE, timer 0, req_o=0, busy_o=0, cmd_o=NOP, a10_o=0, execute_o=0.
REQ-027 Reset wins over every state including PRE/REF; no partial command driven after the reset edge.
REQ-028 After reset release, sequencer idles until status_i=1 and refresh_i=1.

Verification
REQ-029 T_RP=3,T_RFC=8, status=1, refresh pulse-to-level, gnt one cycle after req -> PRECHARGE(a10=1) at t, AUTO REFRESH+execute at t+3, req_o/busy_o low at t+11.
REQ-030 refresh_i held high through two execute pulses -> one PRECHARGE, two AUTO REFRESH 8 cycles apart, req_o continuous, then IDLE.
REQ-031 status_i=0, refresh_i=1 for 50 cycles -> req_o=0, cmd_o=NOP throughout; status_i=1 -> REQ next cycle.
REQ-032 gnt_i withheld 20 cycles -> req_o high, cmd_o=NOP, busy_o=0 all 20; PRECHARGE the cycle after gnt_i sampled high.
REQ-033 reset_i asserted during WAIT_RP -> next cycle all outputs at reset values, no AUTO REFRESH, execute_o never pulses.
REQ-034 status_i and gnt_i dropped during WAIT_RP -> AUTO REFRESH and execute_o still issued on schedule, then IDLE, no chaining.

Source files
------------

// File: rtl/sdram_refresh_sequencer.sv
// -----------------------------------------------------------------------------
// sdram_refresh_sequencer
//
// Issues the SDRAM auto-refresh command sequence on behalf of a refresh
// controller. When a refresh is owed and the device is initialised, the block
// requests the shared command bus from an arbiter. Once granted it drives
// PRECHARGE ALL, waits T_RP, then drives AUTO REFRESH and waits T_RFC. If
// another refresh is still owed at the end of T_RFC, further AUTO REFRESH
// commands are chained without a new PRECHARGE and without releasing the bus.
//
// Parameters
//   T_RP      cycles from PRECHARGE ALL to AUTO REFRESH (2..2^BW_TIMER-1)
//   T_RFC     cycles from AUTO REFRESH to the next command (2..2^BW_TIMER-1)
//   BW_TIMER  wait-timer width in bits
//
// Ports
//   clock_i    single clock, rising-edge active
//   reset_i    synchronous, active-high reset
//   status_i   SDRAM initialised; new or chained sequences start only while high
//   refresh_i  refresh owed (level) from the refresh controller
//   gnt_i      command-bus grant from the arbiter
//   req_o      command-bus request to the arbiter
//   busy_o     this block drives the command bus this cycle
//   cmd_o      {CS_n, RAS_n, CAS_n, WE_n}
//   a10_o      address bit 10, high only with PRECHARGE (all banks)
//   execute_o  one-cycle pulse alongside each AUTO REFRESH
// -----------------------------------------------------------------------------
module sdram_refresh_sequencer #(
    parameter int unsigned T_RP     = 3,
    parameter int unsigned T_RFC    = 8,
    parameter int unsigned BW_TIMER = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       status_i,
    input  logic       refresh_i,
    input  logic       gnt_i,
    output logic       req_o,
    output logic       busy_o,
    output logic [3:0] cmd_o,
    output logic       a10_o,
    output logic       execute_o
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StPre,
        StWaitRp,
        StRef,
        StWaitRfc
    } state_e;

    localparam logic [3:0] CmdNop = 4'b0111;
    localparam logic [3:0] CmdPre = 4'b0010;
    localparam logic [3:0] CmdRef = 4'b0001;

    localparam logic [BW_TIMER-1:0] RpLoad   = BW_TIMER'(T_RP - 1);
    localparam logic [BW_TIMER-1:0] RfcLoad  = BW_TIMER'(T_RFC - 1);
    localparam logic [BW_TIMER-1:0] TimerOne = BW_TIMER'(1);

    state_e              state_q, state_d;
    logic [BW_TIMER-1:0] timer_q, timer_d;

    logic       req_d;
    logic       busy_d;
    logic [3:0] cmd_d;
    logic       a10_d;
    logic       execute_d;

    // Next-state and timer. Loading the timer with (T - 1) in the single-cycle
    // command state and leaving the wait state when it reads 1 places the next
    // command exactly T cycles after the previous one.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StIdle: begin
                if (refresh_i && status_i) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // No timeout: the refresh level cannot legally fall here.
                if (gnt_i) begin
                    state_d = StPre;
                end
            end
            StPre: begin
                timer_d = RpLoad;
                state_d = StWaitRp;
            end
            StWaitRp: begin
                timer_d = timer_q - TimerOne;
                if (timer_q == TimerOne) begin
                    state_d = StRef;
                end
            end
            StRef: begin
                timer_d = RfcLoad;
                state_d = StWaitRfc;
            end
            StWaitRfc: begin
                timer_d = timer_q - TimerOne;
                if (timer_q == TimerOne) begin
                    // Last cycle of T_RFC: the only in-sequence sample of
                    // refresh_i/status_i, by which time the controller has
                    // absorbed the previous execute pulse.
                    if (refresh_i && status_i) begin
                        state_d = StRef;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // together with the state and never glitch.
    always_comb begin
        req_d     = (state_d != StIdle);
        busy_d    = (state_d == StPre) || (state_d == StWaitRp) ||
                    (state_d == StRef) || (state_d == StWaitRfc);
        cmd_d     = CmdNop;
        a10_d     = 1'b0;
        execute_d = 1'b0;
        if (state_d == StPre) begin
            cmd_d = CmdPre;
            a10_d = 1'b1;
        end
        if (state_d == StRef) begin
            cmd_d     = CmdRef;
            execute_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            req_o     <= 1'b0;
            busy_o    <= 1'b0;
            cmd_o     <= CmdNop;
            a10_o     <= 1'b0;
            execute_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            req_o     <= req_d;
            busy_o    <= busy_d;
            cmd_o     <= cmd_d;
            a10_o     <= a10_d;
            execute_o <= execute_d;
        end
    end

endmodule

// File: tb/tb_sdram_refresh_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sdram_refresh_sequencer
//
// Self-checking bench for sdram_refresh_sequencer with default parameters:
// a table of per-cycle vectors, hand-written multi-cycle corner sequences and
// a randomized run against a timeline-based reference model.
// -----------------------------------------------------------------------------
module tb_sdram_refresh_sequencer;

    localparam int unsigned T_RP     = 3;
    localparam int unsigned T_RFC    = 8;
    localparam int unsigned BW_TIMER = 4;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;

    logic       clock;
    logic       reset;
    logic       status;
    logic       refresh;
    logic       gnt;
    logic       req;
    logic       busy;
    logic [3:0] cmd;
    logic       a10;
    logic       execute;

    int checks;
    int passed;

    sdram_refresh_sequencer #(
        .T_RP    (T_RP),
        .T_RFC   (T_RFC),
        .BW_TIMER(BW_TIMER)
    ) dut (
        .clock_i  (clock),
        .reset_i  (reset),
        .status_i (status),
        .refresh_i(refresh),
        .gnt_i    (gnt),
        .req_o    (req),
        .busy_o   (busy),
        .cmd_o    (cmd),
        .a10_o    (a10),
        .execute_o(execute)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       st;
        logic       rf;
        logic       gn;
        logic       e_req;
        logic       e_busy;
        logic [3:0] e_cmd;
        logic       e_a10;
        logic       e_exe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, st, rf, gn,
                                input logic e_req, e_busy, input logic [3:0] e_cmd,
                                input logic e_a10, e_exe);
        vec_t v;
        v.rst = rst; v.st = st; v.rf = rf; v.gn = gn;
        v.e_req = e_req; v.e_busy = e_busy; v.e_cmd = e_cmd;
        v.e_a10 = e_a10; v.e_exe = e_exe;
        return v;
    endfunction

    task automatic check(input string name, input logic e_req, e_busy,
                         input logic [3:0] e_cmd, input logic e_a10, e_exe);
        checks++;
        if ({req, busy, cmd, a10, execute} === {e_req, e_busy, e_cmd, e_a10, e_exe}) begin
            passed++;
        end else begin
            $display("FAIL %s @%0t: got req=%b busy=%b cmd=%b a10=%b exe=%b, want req=%b busy=%b cmd=%b a10=%b exe=%b",
                     name, $time, req, busy, cmd, a10, execute,
                     e_req, e_busy, e_cmd, e_a10, e_exe);
        end
    endtask

    // Apply inputs, then sample outputs 1 time unit after the next rising edge.
    task automatic tick(input logic r, s, f, g);
        reset = r; status = s; refresh = f; gnt = g;
        @(posedge clock);
        #1;
    endtask

    // Reference model: tracks the sequence as a timeline. The cycle a grant is
    // seen fixes the PRECHARGE cycle; AUTO REFRESH lands T_RP later and each
    // chained one T_RFC after the previous; the sequence ends T_RFC after the
    // last refresh unless refresh and status are both high at that boundary.
    int k;
    int m_phase;  // 0 idle, 1 requesting, 2 in sequence
    int m_pre;
    int m_ref;

    task automatic model_step(input logic r, s, f, g);
        k++;
        if (r) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (f && s) m_phase = 1;
        end else if (m_phase == 1) begin
            if (g) begin
                m_phase = 2;
                m_pre   = k;
                m_ref   = k + int'(T_RP);
            end
        end else begin
            if (k == m_ref + int'(T_RFC)) begin
                if (f && s) m_ref = k;
                else m_phase = 0;
            end
        end
    endtask

    task automatic model_check(input string name);
        logic [3:0] c;
        if (m_phase == 0) begin
            check(name, 1'b0, 1'b0, NOP, 1'b0, 1'b0);
        end else if (m_phase == 1) begin
            check(name, 1'b1, 1'b0, NOP, 1'b0, 1'b0);
        end else begin
            c = (k == m_pre) ? PRE : (k == m_ref) ? REF : NOP;
            check(name, 1'b1, 1'b1, c, k == m_pre, k == m_ref);
        end
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        reset   = 1'b1;
        status  = 1'b0;
        refresh = 1'b0;
        gnt     = 1'b0;

        // ---------------- table-driven single sequence ----------------
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, NOP, 0, 0));  // reset
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, NOP, 0, 0));  // nothing owed
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, NOP, 0, 0));  // status blocks
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, NOP, 0, 0));  // REQ
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, NOP, 0, 0));  // REQ, no grant
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, PRE, 1, 0));  // PRECHARGE at t
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, NOP, 0, 0));  // WAIT_RP
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, NOP, 0, 0));  // WAIT_RP
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, REF, 0, 1));  // AUTO REFRESH at t+3
        for (int i = 0; i < int'(T_RFC) - 1; i++) begin
            vecs.push_back(mk(0, 1, 0, 1, 1, 1, NOP, 0, 0));  // WAIT_RFC
        end
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, NOP, 0, 0));  // idle at t+11
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, NOP, 0, 0));  // REQ again
        vecs.push_back(mk(1, 1, 1, 1, 0, 0, NOP, 0, 0));  // reset from REQ
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, NOP, 0, 0));  // idle

        foreach (vecs[i]) begin
            tick(vecs[i].rst, vecs[i].st, vecs[i].rf, vecs[i].gn);
            check($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_busy,
                  vecs[i].e_cmd, vecs[i].e_a10, vecs[i].e_exe);
        end

        // ---------------- chained refresh ----------------
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0);
        check("chain_req", 1, 0, NOP, 0, 0);
        tick(0, 1, 1, 1);
        check("chain_pre", 1, 1, PRE, 1, 0);
        for (int off = 1; off <= int'(T_RP + 2 * T_RFC); off++) begin
            // Refresh still owed at the first T_RFC boundary, not at the second.
            tick(0, 1, (off <= int'(T_RP + T_RFC)), 1);
            if (off == int'(T_RP + 2 * T_RFC))
                check("chain_idle", 0, 0, NOP, 0, 0);
            else if (off == int'(T_RP) || off == int'(T_RP + T_RFC))
                check("chain_ref", 1, 1, REF, 0, 1);
            else
                check("chain_wait", 1, 1, NOP, 0, 0);
        end

        // ---------------- status low blocks requests ----------------
        tick(1, 0, 0, 0);
        for (int i = 0; i < 50; i++) begin
            tick(0, 0, 1, 0);
            check("status_block", 0, 0, NOP, 0, 0);
        end
        tick(0, 1, 1, 0);
        check("status_release_req", 1, 0, NOP, 0, 0);

        // ---------------- grant withheld ----------------
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 1, 0);
            check("gnt_withheld", 1, 0, NOP, 0, 0);
        end
        tick(0, 1, 1, 1);
        check("gnt_late_pre", 1, 1, PRE, 1, 0);

        // ---------------- reset during WAIT_RP ----------------
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0);
        tick(0, 1, 1, 1);
        check("rst_mid_pre", 1, 1, PRE, 1, 0);
        tick(0, 1, 1, 1);
        check("rst_mid_wait", 1, 1, NOP, 0, 0);
        tick(1, 1, 1, 1);
        check("rst_mid_reset", 0, 0, NOP, 0, 0);
        for (int i = 0; i < int'(T_RFC) + 4; i++) begin
            tick(0, 1, 0, 0);
            check("rst_mid_quiet", 0, 0, NOP, 0, 0);
        end

        // ---------------- status and grant dropped during WAIT_RP ----------------
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0);
        tick(0, 1, 1, 1);
        check("drop_pre", 1, 1, PRE, 1, 0);
        for (int off = 1; off <= int'(T_RP + T_RFC) + 2; off++) begin
            tick(0, 0, 1, 0);
            if (off == int'(T_RP))
                check("drop_ref", 1, 1, REF, 0, 1);
            else if (off < int'(T_RP + T_RFC))
                check("drop_wait", 1, 1, NOP, 0, 0);
            else
                check("drop_idle", 0, 0, NOP, 0, 0);
        end

        // ---------------- randomized vs reference model ----------------
        k       = 0;
        m_phase = 0;
        m_pre   = -100;
        m_ref   = -100;
        tick(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        model_check("rand_reset");
        for (int i = 0; i < 3000; i++) begin
            logic r, s, f, g;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 9) < 8);
            f = ($urandom_range(0, 9) < 5);
            g = ($urandom_range(0, 9) < 4);
            tick(r, s, f, g);
            model_step(r, s, f, g);
            model_check("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
